// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared width default, FSM encoding and counter sizing for seq_divider
package seq_divider_pkg;
  localparam int DEF_WIDTH = 32;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/seq_divider_div_step.sv
// seq_divider_div_step: one restoring shift-and-subtract iteration producing one quotient bit
module seq_divider_div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  assign shifted = {rem_i, quot_i[WIDTH-1]};
  // rem < divisor keeps a non-negative difference below 2^WIDTH, so bit WIDTH is the sign
  assign diff    = shifted - {1'b0, dvsr_i};
  assign rem_o   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quot_o  = {quot_i[WIDTH-2:0], ~diff[WIDTH]};
endmodule

// File: rtl/seq_divider.sv
// seq_divider: iterative signed/unsigned divider, one quotient bit per cycle, done pulse on completion
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             div_zero_o
);
  localparam int CW = cnt_w(WIDTH);
  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic [WIDTH-1:0] qo_q, qo_d, ro_q, ro_d;
  logic           qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0] step_rem, step_quot;
  logic           s1_neg, s2_neg;
  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quot_o (step_quot)
  );
  assign s1_neg = signed_i & src1_i[WIDTH-1];
  assign s2_neg = signed_i & src2_i[WIDTH-1];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    dvsr_d  = dvsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: if (start_i) begin
        rem_d   = '0;
        quot_d  = s1_neg ? -src1_i : src1_i;
        dvsr_d  = s2_neg ? -src2_i : src2_i;
        qneg_d  = s1_neg ^ s2_neg;
        rneg_d  = s1_neg;
        cnt_d   = CW'(WIDTH);
        qo_d    = (src2_i == '0) ? '1 : '0;
        ro_d    = (src2_i == '0) ? src1_i : '0;
        dz_d    = (src2_i == '0);
        state_d = (src2_i == '0) ? DONE : RUN;
      end
      RUN: begin
        rem_d   = step_rem;
        quot_d  = step_quot;
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? FIX : RUN;
      end
      FIX: begin
        qo_d    = qneg_q ? -quot_q : quot_q;
        ro_d    = rneg_q ? -rem_q : rem_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      dvsr_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      qo_q    <= '0;
      ro_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      dvsr_q  <= dvsr_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      dz_q    <= dz_d;
    end
  end
  assign busy_o     = state_q != IDLE;
  assign done_o     = state_q == DONE;
  assign quot_o     = qo_q;
  assign rem_o      = ro_q;
  assign div_zero_o = dz_q;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random division runs checked against an arithmetic reference
module tb_seq_divider;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic        busy_o, done_o, div_zero_o;
  logic [31:0] quot_o, rem_o;
  int total = 0;
  int bad = 0;

  seq_divider dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .src1_i     (src1_i),
    .src2_i     (src2_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .quot_o     (quot_o),
    .rem_o      (rem_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit sg, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r, output logic dz);
    longint x, y;
    dz = (b == 0);
    if (dz) begin
      q = '1;
      r = a;
    end else if (sg) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
      q = 32'(x / y);
      r = 32'(x % y);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  task automatic run(input string tag, input bit sg, input logic [31:0] a, input logic [31:0] b,
                     input bit intr);
    logic [31:0] eq, er;
    logic edz;
    int n;
    model(sg, a, b, eq, er, edz);
    @(negedge clk_i);
    start_i = 1'b1; signed_i = sg; src1_i = a; src2_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    chk({tag, ".busy"}, 64'(busy_o), 64'(1));
    n = 0;
    while (!done_o && n < 100) begin
      if (intr) begin
        start_i = (n == 3);
        signed_i = 1'b0; src1_i = 32'd9; src2_i = 32'd3;
      end
      @(posedge clk_i); #1;
      n++;
    end
    start_i = 1'b0;
    chk({tag, ".lat"}, 64'(n), (b == 0) ? 64'd0 : 64'd33);
    chk({tag, ".quot"}, 64'(quot_o), 64'(eq));
    chk({tag, ".rem"}, 64'(rem_o), 64'(er));
    chk({tag, ".dz"}, 64'(div_zero_o), 64'(edz));
    @(posedge clk_i); #1;
    chk({tag, ".pulse"}, 64'(done_o), 64'd0);
    chk({tag, ".idle"}, 64'(busy_o), 64'd0);
    chk({tag, ".hold"}, 64'(quot_o), 64'(eq));
  endtask

  initial begin
    logic [31:0] a, b;
    bit sg;
    #12;
    chk("rst.outs", {28'd0, busy_o, done_o, div_zero_o, 1'b0, quot_o, rem_o[31:4]}, 64'd0);
    chk("rst.rem", 64'(rem_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run("u100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    run("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run("u-7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run("u5_0", 1'b0, 32'd5, 32'd0, 1'b0);
    run("s5_0", 1'b1, 32'd5, 32'd0, 1'b0);
    run("sovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run("umax_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    run("intr", 1'b0, 32'd100, 32'd7, 1'b1);
    run("u9_3", 1'b0, 32'd9, 32'd3, 1'b0);
    @(negedge clk_i);
    start_i = 1'b1; signed_i = 1'b0; src1_i = 32'd100; src2_i = 32'd7;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    chk("arst.busy", 64'(busy_o), 64'd0);
    chk("arst.done", 64'(done_o), 64'd0);
    chk("arst.res", {quot_o, rem_o}, 64'd0);
    chk("arst.dz", 64'(div_zero_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run("post_rst", 1'b0, 32'd100, 32'd7, 1'b0);
    for (int i = 0; i < 40; i++) begin
      sg = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      if (i % 7 == 0) a = 32'h8000_0000;
      run("rand", sg, a, b, 1'b0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
